// File: rtl/adc_scan_sequencer.sv
// Scan sequencer: steps through the masked mux channels, converts each one and buffers
// {channel, result} in a first-word-fall-through FIFO. Define ADC_SEQ_AVG_EN for 4x averaging.
module adc_scan_sequencer #(
    parameter  int ADC_WIDTH      = 12,
    parameter  int NUM_CH         = 4,
    parameter  int SETTLE_CYCLES  = 16,
    parameter  int TIMEOUT_CYCLES = 65535,
    parameter  int FIFO_DEPTH     = 4,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   sys_clk_i,
    input  logic                   reset_ni,
    input  logic                   enable_i,
    input  logic                   auto_mode_i,
    input  logic                   sw_trig_i,
    input  logic [NUM_CH-1:0]      ch_mask_i,
    output logic                   adc_start_o,
    input  logic                   adc_busy_i,
    input  logic                   adc_eoc_i,
    input  logic [ADC_WIDTH-1:0]   adc_data_i,
    output logic [CH_W-1:0]        mux_sel_o,
    input  logic                   fifo_rd_i,
    output logic [CH_W+ADC_WIDTH-1:0] fifo_dout_o,
    output logic                   fifo_empty_o,
    output logic                   fifo_full_o,
    output logic                   overflow_o,
    output logic                   timeout_err_o,
    input  logic                   err_clr_i,
    output logic                   scan_done_o,
    output logic                   seq_busy_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DW    = CH_W + ADC_WIDTH;
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_START, S_WAIT, S_STORE, S_NEXT
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_CH-1:0]     rem_q, rem_d;
    logic [CH_W-1:0]       mux_q, mux_d;
    logic [SET_W-1:0]      set_cnt_q, set_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [ADC_WIDTH-1:0]  res_q, res_d;
    logic                  ovf_q, ovf_d;
    logic                  to_err_q, to_err_d;
`ifdef ADC_SEQ_AVG_EN
    logic [ADC_WIDTH+1:0]  acc_q, acc_d;
    logic [1:0]            conv_q, conv_d;
    logic [ADC_WIDTH+1:0]  sum;
`endif

    logic                  load_scan;
    logic [NUM_CH-1:0]     load_mask;
    logic                  to_expired;
    logic                  fifo_wr, wr_ok, rd_ok;
    logic                  ovf_set, to_set;

    logic [DW-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CH_W'(i);
        end
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty_o = (count_q == '0);
    assign fifo_full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign rd_ok        = fifo_rd_i && !fifo_empty_o;
    // A full FIFO still accepts a write when the same cycle pops the head.
    assign wr_ok        = fifo_wr && (!fifo_full_o || rd_ok);
    assign to_expired   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            mux_q     <= '0;
            set_cnt_q <= '0;
            to_cnt_q  <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            to_err_q  <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
            acc_q     <= '0;
            conv_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            mux_q     <= mux_d;
            set_cnt_q <= set_cnt_d;
            to_cnt_q  <= to_cnt_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            to_err_q  <= to_err_d;
`ifdef ADC_SEQ_AVG_EN
            acc_q     <= acc_d;
            conv_q    <= conv_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        mux_d     = mux_q;
        set_cnt_d = set_cnt_q;
        to_cnt_d  = to_cnt_q;
        res_d     = res_q;
        load_scan = 1'b0;
        load_mask = rem_q;
        fifo_wr   = 1'b0;
        to_set    = 1'b0;
`ifdef ADC_SEQ_AVG_EN
        acc_d     = acc_q;
        conv_d    = conv_q;
        sum       = acc_q + (ADC_WIDTH+2)'(adc_data_i);
`endif
        unique case (state_q)
            S_IDLE: begin
                if ((sw_trig_i || auto_mode_i) && (ch_mask_i != '0)) begin
                    load_scan = 1'b1;
                    load_mask = ch_mask_i;
                end
            end
            S_SELECT: begin
                if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d  = S_START;
                    to_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            S_START: begin
                if (to_expired) begin
                    to_set  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (adc_busy_i) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (adc_eoc_i) begin
`ifdef ADC_SEQ_AVG_EN
                    if (conv_q == 2'd3) begin
                        res_d   = sum[ADC_WIDTH+1:2];
                        acc_d   = '0;
                        conv_d  = '0;
                        state_d = S_STORE;
                    end else begin
                        acc_d    = sum;
                        conv_d   = conv_q + 2'd1;
                        to_cnt_d = '0;
                        state_d  = S_START;
                    end
`else
                    res_d   = adc_data_i;
                    state_d = S_STORE;
`endif
                end else if (to_expired) begin
                    to_set  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_STORE: begin
                fifo_wr = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (rem_q != '0) begin
                    load_scan = 1'b1;
                    load_mask = rem_q;
                end else if (auto_mode_i && (ch_mask_i != '0)) begin
                    load_scan = 1'b1;
                    load_mask = ch_mask_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // m & (m-1) drops the channel just selected, so masked-off channels cost no cycles.
        if (load_scan) begin
            state_d   = S_SELECT;
            mux_d     = lowest_ch(load_mask);
            rem_d     = load_mask & (load_mask - NUM_CH'(1));
            set_cnt_d = '0;
`ifdef ADC_SEQ_AVG_EN
            acc_d     = '0;
            conv_d    = '0;
`endif
        end

        if (!enable_i) begin
            state_d = S_IDLE;
            fifo_wr = 1'b0;
            to_set  = 1'b0;
        end

        ovf_set  = fifo_wr && !wr_ok;
        ovf_d    = ovf_set ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
        to_err_d = to_set  ? 1'b1 : (err_clr_i ? 1'b0 : to_err_q);
    end

    always_comb begin
        adc_start_o   = (state_q == S_START);
        seq_busy_o    = (state_q != S_IDLE);
        scan_done_o   = (state_q == S_NEXT) && (rem_q == '0) && enable_i;
        mux_sel_o     = mux_q;
        overflow_o    = ovf_q;
        timeout_err_o = to_err_q;
        fifo_dout_o   = fifo_empty_o ? '0 : mem[rd_ptr_q];
    end

    always_ff @(posedge sys_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rd_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (wr_ok && !rd_ok)      count_q <= count_q + CNT_ONE;
            else if (rd_ok && !wr_ok) count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (wr_ok) mem[wr_ptr_q] <= {mux_q, res_q};
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a small behavioural ADC core model.
module tb_adc_scan_sequencer;

    localparam int AW     = 12;
    localparam int NCH    = 4;
    localparam int CW     = 2;
    localparam int SETTLE = 4;
    localparam int TMO    = 40;
    localparam int DEPTH  = 4;
    localparam logic [22:0] RST_EXP = {1'b0, 2'b00, 1'b1, 1'b0, 14'h0000, 4'b0000};

    logic clk = 1'b0;
    logic rstN;
    logic enable, autoMode, swTrig, adcStart, adcBusy, adcEoc;
    logic [NCH-1:0] chMask;
    logic [AW-1:0] adcData;
    logic [CW-1:0] muxSel;
    logic fifoRd, fifoEmpty, fifoFull, overflow, timeoutErr, errClr, scanDone, seqBusy;
    logic [CW+AW-1:0] fifoDout;

    int checks = 0;
    int passes = 0;
    logic [AW-1:0] dataQ[$];
    bit adcAlive = 1'b1;
    int adcLat = 0;

    always #5 clk = ~clk;

    adc_scan_sequencer #(
        .ADC_WIDTH(AW), .NUM_CH(NCH), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk_i(clk), .reset_ni(rstN), .enable_i(enable), .auto_mode_i(autoMode),
        .sw_trig_i(swTrig), .ch_mask_i(chMask), .adc_start_o(adcStart), .adc_busy_i(adcBusy),
        .adc_eoc_i(adcEoc), .adc_data_i(adcData), .mux_sel_o(muxSel), .fifo_rd_i(fifoRd),
        .fifo_dout_o(fifoDout), .fifo_empty_o(fifoEmpty), .fifo_full_o(fifoFull),
        .overflow_o(overflow), .timeout_err_o(timeoutErr), .err_clr_i(errClr),
        .scan_done_o(scanDone), .seq_busy_o(seqBusy)
    );

    // ADC core model: accepts a start, stays busy a few cycles, then pulses eoc with the next queued value.
    initial begin
        adcBusy = 1'b0;
        adcEoc  = 1'b0;
        adcData = '0;
        forever begin
            @(negedge clk);
            adcEoc = 1'b0;
            if (adcBusy) begin
                if (adcLat == 0) begin
                    adcEoc  = 1'b1;
                    adcBusy = 1'b0;
                    adcData = (dataQ.size() > 0) ? dataQ.pop_front() : '0;
                end else begin
                    adcLat--;
                end
            end else if (adcAlive && adcStart) begin
                adcBusy = 1'b1;
                adcLat  = 3;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop;
        fifoRd = 1'b1;
        tick();
        fifoRd = 1'b0;
    endtask

    task automatic test_reset;
        logic [22:0] obs;
        rstN = 1'b0;
        repeat (3) tick();
        obs = {adcStart, muxSel, fifoEmpty, fifoFull, fifoDout, overflow, timeoutErr, scanDone, seqBusy};
        checks++;
        if (obs !== RST_EXP) $display("[TB] FAIL reset_outputs: got %h expected %h", obs, RST_EXP);
        else passes++;
        rstN = 1'b1;
        repeat (2) tick();
        checks++;
        if (seqBusy !== 1'b0) $display("[TB] FAIL idle_after_reset: got %b expected 0", seqBusy);
        else passes++;
    endtask

    task automatic test_basic_scan;
        int cyc;
        int dones;
        logic [CW+AW-1:0] exp;
        dataQ = {12'h123, 12'hABC};
        chMask = 4'b1010;
        swTrig = 1'b1;
        tick();
        swTrig = 1'b0;
        cyc = 0;
        while (!adcStart && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (cyc !== SETTLE) $display("[TB] FAIL settle_cycles: got %0d expected %0d", cyc, SETTLE);
        else passes++;
        checks++;
        if (muxSel !== 2'd1) $display("[TB] FAIL first_channel: got %0d expected 1", muxSel);
        else passes++;
        chMask = 4'b0000;
        dones = 0;
        cyc = 0;
        while (cyc < 500) begin
            if (scanDone) dones++;
            if (!seqBusy) break;
            tick();
            cyc++;
        end
        checks++;
        if (seqBusy !== 1'b0) $display("[TB] FAIL scan_finish: got busy=%b expected 0", seqBusy);
        else passes++;
        checks++;
        if (dones !== 1) $display("[TB] FAIL scan_done_count: got %0d expected 1", dones);
        else passes++;
        exp = {2'd1, 12'h123};
        checks++;
        if (fifoDout !== exp) $display("[TB] FAIL fifo_entry0: got %h expected %h", fifoDout, exp);
        else passes++;
        pop();
        exp = {2'd3, 12'hABC};
        checks++;
        if (fifoDout !== exp) $display("[TB] FAIL fifo_entry1: got %h expected %h", fifoDout, exp);
        else passes++;
        pop();
        checks++;
        if (fifoEmpty !== 1'b1) $display("[TB] FAIL fifo_drained: got %b expected 1", fifoEmpty);
        else passes++;
    endtask

    task automatic test_overflow;
        int cyc;
        logic [CW+AW-1:0] exp;
        dataQ = {12'h101, 12'h102, 12'h103, 12'h104, 12'h105};
        chMask = 4'b1111;
        autoMode = 1'b1;
        cyc = 0;
        while (!fifoFull && cyc < 1000) begin tick(); cyc++; end
        checks++;
        if (fifoFull !== 1'b1) $display("[TB] FAIL fifo_full_reached: got %b expected 1", fifoFull);
        else passes++;
        checks++;
        if (overflow !== 1'b0) $display("[TB] FAIL overflow_early: got %b expected 0", overflow);
        else passes++;
        cyc = 0;
        while (!overflow && cyc < 500) begin tick(); cyc++; end
        checks++;
        if (overflow !== 1'b1) $display("[TB] FAIL overflow_set: got %b expected 1", overflow);
        else passes++;
        autoMode = 1'b0;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        checks++;
        if (fifoFull !== 1'b1) $display("[TB] FAIL full_kept: got %b expected 1", fifoFull);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            exp = {i[1:0], 12'h101 + i[11:0]};
            checks++;
            if (fifoDout !== exp) $display("[TB] FAIL ovf_entry%0d: got %h expected %h", i, fifoDout, exp);
            else passes++;
            pop();
        end
        checks++;
        if (fifoEmpty !== 1'b1) $display("[TB] FAIL ovf_drained: got %b expected 1", fifoEmpty);
        else passes++;
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        checks++;
        if (overflow !== 1'b0) $display("[TB] FAIL overflow_clear: got %b expected 0", overflow);
        else passes++;
    endtask

    task automatic test_timeout;
        int cyc;
        adcAlive = 1'b0;
        chMask = 4'b0001;
        swTrig = 1'b1;
        tick();
        swTrig = 1'b0;
        cyc = 0;
        while (!adcStart && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (adcStart !== 1'b1) $display("[TB] FAIL to_start_seen: got %b expected 1", adcStart);
        else passes++;
        repeat (TMO - 1) tick();
        checks++;
        if (timeoutErr !== 1'b0) $display("[TB] FAIL timeout_early: got %b expected 0", timeoutErr);
        else passes++;
        tick();
        checks++;
        if (timeoutErr !== 1'b1) $display("[TB] FAIL timeout_set: got %b expected 1", timeoutErr);
        else passes++;
        checks++;
        if ({seqBusy, adcStart, fifoEmpty} !== 3'b001)
            $display("[TB] FAIL timeout_abort: got busy/start/empty=%b expected 001", {seqBusy, adcStart, fifoEmpty});
        else passes++;
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        checks++;
        if (timeoutErr !== 1'b0) $display("[TB] FAIL timeout_clear: got %b expected 0", timeoutErr);
        else passes++;
        swTrig = 1'b1;
        tick();
        swTrig = 1'b0;
        cyc = 0;
        while (!adcStart && cyc < 100) begin tick(); cyc++; end
        repeat (TMO - 1) tick();
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        checks++;
        if (timeoutErr !== 1'b1) $display("[TB] FAIL set_beats_clear: got %b expected 1", timeoutErr);
        else passes++;
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        adcAlive = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_enable_drop;
        int cyc;
        chMask = 4'b0100;
        swTrig = 1'b1;
        tick();
        swTrig = 1'b0;
        cyc = 0;
        while (!adcStart && cyc < 100) begin tick(); cyc++; end
        while (adcStart && cyc < 200) begin tick(); cyc++; end
        checks++;
        if ({seqBusy, muxSel} !== 3'b110) $display("[TB] FAIL wait_on_ch2: got busy/mux=%b expected 110", {seqBusy, muxSel});
        else passes++;
        enable = 1'b0;
        tick();
        checks++;
        if ({seqBusy, adcStart} !== 2'b00) $display("[TB] FAIL disable_idle: got busy/start=%b expected 00", {seqBusy, adcStart});
        else passes++;
        repeat (10) tick();
        enable = 1'b1;
        repeat (3) tick();
        checks++;
        if ({seqBusy, fifoEmpty} !== 2'b01) $display("[TB] FAIL late_eoc_ignored: got busy/empty=%b expected 01", {seqBusy, fifoEmpty});
        else passes++;
    endtask

    task automatic test_avg;
        int cyc;
        logic [CW+AW-1:0] exp;
        dataQ = {12'd100, 12'd101, 12'd102, 12'd104};
        chMask = 4'b0001;
        swTrig = 1'b1;
        tick();
        swTrig = 1'b0;
        cyc = 0;
        while (seqBusy && cyc < 500) begin tick(); cyc++; end
        exp = {2'd0, 12'd101};
        checks++;
        if (fifoDout !== exp) $display("[TB] FAIL avg_result: got %h expected %h", fifoDout, exp);
        else passes++;
        pop();
        checks++;
        if (fifoEmpty !== 1'b1) $display("[TB] FAIL avg_single_entry: got %b expected 1", fifoEmpty);
        else passes++;
    endtask

    task automatic test_reset_midscan;
        int cyc;
        logic [22:0] obs;
        dataQ = {12'h055, 12'h0AA};
        chMask = 4'b0011;
        swTrig = 1'b1;
        tick();
        swTrig = 1'b0;
        cyc = 0;
        while (seqBusy && cyc < 500) begin tick(); cyc++; end
        checks++;
        if ({fifoEmpty, fifoFull} !== 2'b00) $display("[TB] FAIL two_entries: got empty/full=%b expected 00", {fifoEmpty, fifoFull});
        else passes++;
        chMask = 4'b0001;
        swTrig = 1'b1;
        tick();
        swTrig = 1'b0;
        cyc = 0;
        while (!adcStart && cyc < 100) begin tick(); cyc++; end
        #2 rstN = 1'b0;
        #1;
        obs = {adcStart, muxSel, fifoEmpty, fifoFull, fifoDout, overflow, timeoutErr, scanDone, seqBusy};
        checks++;
        if (obs !== RST_EXP) $display("[TB] FAIL midscan_reset: got %h expected %h", obs, RST_EXP);
        else passes++;
        tick();
        rstN = 1'b1;
        repeat (3) tick();
        checks++;
        if ({seqBusy, fifoEmpty} !== 2'b01) $display("[TB] FAIL after_reset_release: got busy/empty=%b expected 01", {seqBusy, fifoEmpty});
        else passes++;
    endtask

    initial begin
        rstN = 1'b0;
        enable = 1'b1;
        autoMode = 1'b0;
        swTrig = 1'b0;
        chMask = '0;
        fifoRd = 1'b0;
        errClr = 1'b0;
        test_reset();
`ifdef ADC_SEQ_AVG_EN
        test_avg();
`else
        test_basic_scan();
        test_overflow();
`endif
        test_timeout();
        test_enable_drop();
        test_reset_midscan();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
